uart_rx: RTL
============

# uart_rx

Serial-to-parallel UART receiver: the stage directly downstream of `uart_tx`. It is the far end of the serial link, or the loopback partner in test. It recovers 8N1 frames (one start bit, 8 data bits LSB first, one stop bit) from the asynchronous `rx` line using the same `period` (clocks per bit) convention as the transmitter. Each received byte is presented as a one-cycle `out_sync` pulse with `out_data`. A bad stop bit raises a one-cycle `frame_err` pulse instead.

## Interface
- `MIN_PERIOD`, default 4: smallest supported bit period. A lower `period` is clamped to this value when latched.
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `period`  in  32  clocks per bit. Latched at start-edge detection and held for the whole frame.
- `rx`  in  1  serial line, asynchronous to `clk`, idle high
- `out_sync`  out  1  one-cycle pulse: `out_data` holds a newly received byte
- `out_data`  out  8  last good byte. Unchanged on error or false start.
- `frame_err`  out  1  one-cycle pulse: the stop bit was sampled low

## Operation
- `rx` passes through a 2-flop synchronizer to give `rx_s`. A third flop holds `rx_d`, and falling edge = `rx_d & ~rx_s`.
- States: IDLE, START, DATA, STOP, BREAK. Encoding is taken from the shared package.
- **IDLE**
  - On a falling edge: latch `per = max(period, MIN_PERIOD)`, set `half = per >> 1`, clear the bit counter `cnt`, go to START.
- **START**
  - Count up to `half-1`, then sample `rx_s`.
  - If `rx_s` = 1: false start, return to IDLE with no output.
  - If `rx_s` = 0: clear `cnt`, go to DATA.
- **DATA**
  - Sample every `per` cycles (at `cnt == per-1`) and shift into `shreg` LSB first.
  - The 3-bit bit index goes 0..7. Index 7 wraps to 0 and moves to STOP.
- **STOP**
  - Sample after `per` cycles.
  - If 1: load `out_data <= shreg`, pulse `out_sync`, go to IDLE. The next start edge is accepted from the following cycle, so half a stop bit is tolerated for back-to-back frames.
  - If 0: pulse `frame_err`, go to BREAK.
- **BREAK**
  - Wait until `rx_s` = 1, then go to IDLE. A line held low never produces spurious frames.
- Changes to `period` while a frame is in progress have no effect. The new value is used from the next start edge.

## Timing
- Reset values: `out_sync` = 0, `frame_err` = 0, `out_data` = 8'h00. State is IDLE, and the synchronizer flops are reset to 1 (idle line).
- `rst` asserted mid-frame aborts at once: no pulse, `out_data` keeps its reset value.
- T0 is the cycle in which the falling edge is detected, which is 2 clocks after the `rx` pin transition. Relative to T0:
  - Start sample: T0 + `half`.
  - Data bit k sample: T0 + `half` + (k+1)·`per`.
  - Stop sample: T0 + `half` + 9·`per`.
- `out_sync` and `frame_err` are registered and go high for one cycle, the cycle after the stop sample.
- Latency from the pin falling edge to `out_sync`: `half` + 9·`per` + 3 cycles. For `per` = 16 that is 155 cycles.
- `out_data` changes only in the same cycle `out_sync` rises, and is stable until the next good frame.
- `out_sync` and `frame_err` are never asserted together.

## Structure
- Shared package `uart_pkg` holds:
  - the state encodings as localparams;
  - the period width (32);
  - `MIN_PERIOD`;
  - the frame length (8 data bits).
- `uart_tx` is updated to import the same package.
- One sub-module: `uart_rx_sync`, which is the 2-flop synchronizer plus edge detector with async reset to 1.
- The bit timer (`cnt`, `per`, `half`) and the FSM stay in `uart_rx`.

## Test plan
- **Loopback:** `uart_tx` → `uart_rx`, `period`=16, send 0xA5. Expect one `out_sync` 155 cycles after the tx start edge, `out_data`=0xA5, and no `frame_err`.
- **Glitch:** drive `rx` low for 5 cycles at `period`=16. Expect no `out_sync`, no `frame_err`, back in IDLE. A following 0x3C is received correctly.
- **Bad stop:**
  - Send frame 0x81 with the stop bit forced low, then hold `rx` low for 40 cycles. Expect a single `frame_err` pulse, `out_data` unchanged, state BREAK.
  - Release `rx` high, then send 0x3C. Expect `out_data`=0x3C.
- **Back-to-back:** at `period`=8, send 0x00 then 0xFF with no idle gap. Expect two `out_sync` pulses, 80 cycles apart, carrying 0x00 then 0xFF.
- **Period change mid-frame:** `period` changes from 16 to 32 during data bit 3. The frame is still received as sent at 16, and the next frame is received at 32.
- **Reset and clamp:**
  - Assert `rst` during data bit 5. Expect outputs 0 immediately, no pulse, and a clean reception of the next frame.
  - Set `period`=2. Expect it to be clamped to 4, and a frame sent at 4 to be received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART transmitter and receiver.
//   PERIOD_W    width of the clocks-per-bit value
//   MIN_PERIOD  smallest bit period the receiver accepts (lower values clamp)
//   FRAME_BITS  data bits per 8N1 frame
//   ST_*        receiver state encodings, wrapped by rx_state_e
package uart_pkg;

  localparam int          PERIOD_W   = 32;
  localparam int unsigned MIN_PERIOD = 4;
  localparam int          FRAME_BITS = 8;
  localparam int          BIT_IDX_W  = $clog2(FRAME_BITS);
  localparam int          STATE_W    = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_START = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA  = 3'd2;
  localparam logic [STATE_W-1:0] ST_STOP  = 3'd3;
  localparam logic [STATE_W-1:0] ST_BREAK = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_STOP  = ST_STOP,
    S_BREAK = ST_BREAK
  } rx_state_e;

  // Raise a requested bit period to the supported floor.
  function automatic logic [PERIOD_W-1:0] clamp_period(
    input logic [PERIOD_W-1:0] p,
    input logic [PERIOD_W-1:0] lo
  );
    return (p < lo) ? lo : p;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, bit period and received-byte outputs of uart_rx.
//   rx        serial line, idle high
//   period    clocks per bit
//   out_sync  one-cycle pulse, out_data holds a new byte
//   out_data  last good byte
//   frame_err one-cycle pulse, stop bit sampled low
// master drives the line (transmitter / bench), slave is the receiver.
interface uart_rx_if;
  import uart_pkg::*;

  logic                  rx;
  logic [PERIOD_W-1:0]   period;
  logic                  out_sync;
  logic [FRAME_BITS-1:0] out_data;
  logic                  frame_err;

  modport master (
    output rx,
    output period,
    input  out_sync,
    input  out_data,
    input  frame_err
  );

  modport slave (
    input  rx,
    input  period,
    output out_sync,
    output out_data,
    output frame_err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous rx pin plus a
// falling-edge detector. All flops reset to 1 so an idle line never looks
// like a start edge coming out of reset.
//   clk, rst  system clock, async active-high reset
//   i_rx      raw serial pin
//   o_rx_s    synchronized line level
//   o_fall    high for one cycle when the synchronized line goes 1 -> 0
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  // Synchronizer chain plus one delay stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_dly  <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_rx_s = r_sync;
  assign o_fall = r_dly & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. Recovers a byte from the serial line using the
// same clocks-per-bit convention as uart_tx. A good frame yields a one-cycle
// out_sync with out_data; a low stop bit yields a one-cycle frame_err and the
// receiver then waits for the line to return high.
//   MIN_PERIOD  lower bound applied to period when a frame starts
//   clk, rst    system clock, async active-high reset
//   bus         uart_rx_if slave: rx, period in; out_sync, out_data, frame_err out
module uart_rx #(
  parameter int unsigned MIN_PERIOD = uart_pkg::MIN_PERIOD
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);
  import uart_pkg::*;

  localparam logic [PERIOD_W-1:0]  MIN_PER_C = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0]  ONE_C     = PERIOD_W'(1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(FRAME_BITS - 1);

  logic w_rx_s;
  logic w_fall;

  rx_state_e             r_state,     w_state_nxt;
  logic [PERIOD_W-1:0]   r_cnt,       w_cnt_nxt;
  logic [PERIOD_W-1:0]   r_per,       w_per_nxt;
  logic [PERIOD_W-1:0]   r_half,      w_half_nxt;
  logic [BIT_IDX_W-1:0]  r_bit,       w_bit_nxt;
  logic [FRAME_BITS-1:0] r_shreg,     w_shreg_nxt;
  logic [FRAME_BITS-1:0] r_out_data,  w_out_data_nxt;
  logic                  r_out_sync,  w_out_sync_nxt;
  logic                  r_frame_err, w_frame_err_nxt;
  logic [PERIOD_W-1:0]   w_per_clamp;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_rx   (bus.rx),
    .o_rx_s (w_rx_s),
    .o_fall (w_fall)
  );

  assign w_per_clamp = clamp_period(bus.period, MIN_PER_C);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bit timer, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_per       <= MIN_PER_C;
      r_half      <= MIN_PER_C >> 1;
      r_bit       <= '0;
      r_shreg     <= '0;
      r_out_data  <= 8'h00;
      r_out_sync  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_per       <= w_per_nxt;
      r_half      <= w_half_nxt;
      r_bit       <= w_bit_nxt;
      r_shreg     <= w_shreg_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_sync  <= w_out_sync_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  // Next-state and datapath decode. The period is captured only at the
  // start edge so that changes mid-frame cannot disturb the bit timing.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_per_nxt       = r_per;
    w_half_nxt      = r_half;
    w_bit_nxt       = r_bit;
    w_shreg_nxt     = r_shreg;
    w_out_data_nxt  = r_out_data;
    w_out_sync_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_per_nxt   = w_per_clamp;
          w_half_nxt  = w_per_clamp >> 1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      // Sample mid start bit; a high line here was only a glitch.
      S_START: begin
        if (r_cnt == (r_half - ONE_C)) begin
          w_cnt_nxt = '0;
          w_bit_nxt = '0;
          if (w_rx_s) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DATA;
          end
        end else begin
          w_cnt_nxt = r_cnt + ONE_C;
        end
      end

      // LSB arrives first, so shift in from the top.
      S_DATA: begin
        if (r_cnt == (r_per - ONE_C)) begin
          w_cnt_nxt   = '0;
          w_shreg_nxt = {w_rx_s, r_shreg[FRAME_BITS-1:1]};
          w_bit_nxt   = r_bit + BIT_IDX_W'(1);
          if (r_bit == LAST_BIT) begin
            w_state_nxt = S_STOP;
          end else begin
            w_state_nxt = S_DATA;
          end
        end else begin
          w_cnt_nxt = r_cnt + ONE_C;
        end
      end

      S_STOP: begin
        if (r_cnt == (r_per - ONE_C)) begin
          w_cnt_nxt = '0;
          if (w_rx_s) begin
            w_out_data_nxt = r_shreg;
            w_out_sync_nxt = 1'b1;
            w_state_nxt    = S_IDLE;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = S_BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt + ONE_C;
        end
      end

      // A line held low must not be mistaken for a stream of start bits.
      S_BREAK: begin
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_BREAK;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.out_sync  = r_out_sync;
  assign bus.out_data  = r_out_data;
  assign bus.frame_err = r_frame_err;

endmodule
